// File: rtl/embertrail_data_mem.sv
// Two-bank, word-addressed data memory responder with programmable wait states and a one-cycle ack.
// Define EMBERTRAIL_DMEM_CLEAR_EN to add a post-reset sweep that zeroes both banks.
module embertrail_data_mem #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [31:0] iDataAddrBus,
    input  logic [31:0] iDataDataBus,
    input  logic        iDataMem1RW,
    input  logic        iDataMem2RW,
    input  logic        iData1BusEn,
    input  logic        iData2BusEn,
    output logic [31:0] oDataDataBus,
    output logic        oAck,
    output logic        oBusy
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef EMBERTRAIL_DMEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                bank2_q, bank2_d;
    logic                wr_q, wr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
`ifdef EMBERTRAIL_DMEM_CLEAR_EN
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
`endif

    logic [31:0]         mem1 [DEPTH];
    logic [31:0]         mem2 [DEPTH];
    logic                mem1_we, mem2_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [31:0]         mem_wdata;

    logic unused_addr_hi;
    assign unused_addr_hi = ^iDataAddrBus[31:ADDR_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bank2_d   = bank2_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        mem1_we   = 1'b0;
        mem2_we   = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
`ifdef EMBERTRAIL_DMEM_CLEAR_EN
        sweep_d   = sweep_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Bank 1 wins a simultaneous request; the bank 2 request is dropped.
                if (iData1BusEn || iData2BusEn) begin
                    addr_d  = iDataAddrBus[ADDR_W-1:0];
                    wdata_d = iDataDataBus;
                    bank2_d = !iData1BusEn;
                    wr_d    = iData1BusEn ? iDataMem1RW : iDataMem2RW;
                    cnt_d   = 4'(WAIT_STATES);
                    // WAIT_STATES=0 still passes through WAIT once, keeping latency at 1+WAIT_STATES.
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    if (wr_q) begin
                        mem1_we = !bank2_q;
                        mem2_we = bank2_q;
                    end else begin
                        rdata_d = bank2_q ? mem2[addr_q] : mem1[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
`ifdef EMBERTRAIL_DMEM_CLEAR_EN
            S_CLEAR: begin
                mem1_we   = 1'b1;
                mem2_we   = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + ADDR_W'(1);
                if (sweep_q == '1) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A pending write that has not reached the ACK edge is discarded by reset.
        if (iReset) begin
            mem1_we = 1'b0;
            mem2_we = 1'b0;
        end

        ack_d  = (state_d == S_ACK);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            bank2_q <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= RESET_BUSY;
`ifdef EMBERTRAIL_DMEM_CLEAR_EN
            sweep_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bank2_q <= bank2_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef EMBERTRAIL_DMEM_CLEAR_EN
            sweep_q <= sweep_d;
`endif
        end
    end

    always_ff @(posedge iClock) begin
        if (mem1_we) begin
            mem1[mem_waddr] <= mem_wdata;
        end
        if (mem2_we) begin
            mem2[mem_waddr] <= mem_wdata;
        end
    end

    assign oDataDataBus = rdata_q;
    assign oAck         = ack_q;
    assign oBusy        = busy_q;
endmodule

// File: tb/tb_embertrail_data_mem.sv
// Directed self-checking bench for embertrail_data_mem (WAIT_STATES=2, ADDR_W=8).
// Covers the EMBERTRAIL_DMEM_CLEAR_EN build as well when that macro is defined.
module tb_embertrail_data_mem;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned WAIT_STATES = 2;
    localparam int          EXP_LAT     = 3;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic [31:0] iDataAddrBus = '0;
    logic [31:0] iDataDataBus = '0;
    logic        iDataMem1RW = 1'b0;
    logic        iDataMem2RW = 1'b0;
    logic        iData1BusEn = 1'b0;
    logic        iData2BusEn = 1'b0;
    logic [31:0] oDataDataBus;
    logic        oAck;
    logic        oBusy;

    int checks   = 0;
    int failures = 0;

    embertrail_data_mem #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iDataAddrBus (iDataAddrBus),
        .iDataDataBus (iDataDataBus),
        .iDataMem1RW  (iDataMem1RW),
        .iDataMem2RW  (iDataMem2RW),
        .iData1BusEn  (iData1BusEn),
        .iData2BusEn  (iData2BusEn),
        .oDataDataBus (oDataDataBus),
        .oAck         (oAck),
        .oBusy        (oBusy)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic count_acks(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge iClock); #1;
            if (oAck) c++;
        end
    endtask

    // Waits (bounded) for oBusy to drop; cycles stays 0 if it never does.
    task automatic wait_not_busy(output int cycles, output int acks);
        cycles = 0;
        acks   = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge iClock); #1;
            if (oAck) acks++;
            if (!oBusy) begin
                cycles = i;
                break;
            end
        end
    endtask

    // One request; inputs are scrambled right after capture to show they no longer matter.
    task automatic access(input string tag, input logic en1, input logic en2,
                          input logic rw1, input logic rw2,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd);
        int lat;
        @(negedge iClock);
        iData1BusEn  = en1;
        iData2BusEn  = en2;
        iDataMem1RW  = rw1;
        iDataMem2RW  = rw2;
        iDataAddrBus = addr;
        iDataDataBus = wdata;
        @(posedge iClock); #1;
        iData1BusEn  = 1'b0;
        iData2BusEn  = 1'b0;
        iDataMem1RW  = ~rw1;
        iDataMem2RW  = ~rw2;
        iDataAddrBus = 32'hFFFF_FFFF;
        iDataDataBus = 32'h0BAD_F00D;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge iClock); #1;
            if (oAck) begin
                lat = i;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(EXP_LAT));
        check({tag, ".rdata"}, oDataDataBus, exp_rd);
        @(posedge iClock); #1;
        check({tag, ".ack_one_cycle"}, {31'b0, oAck}, 32'd0);
        check({tag, ".busy_idle"}, {31'b0, oBusy}, 32'd0);
    endtask

    initial begin
        int c;
        int cyc;
        int acks;

        repeat (3) @(posedge iClock);
        #1;
        check("reset.rdata", oDataDataBus, 32'h0);
        check("reset.ack", {31'b0, oAck}, 32'd0);
`ifdef EMBERTRAIL_DMEM_CLEAR_EN
        check("reset.busy", {31'b0, oBusy}, 32'd1);
`else
        check("reset.busy", {31'b0, oBusy}, 32'd0);
`endif
        @(negedge iClock);
        iReset = 1'b0;

`ifdef EMBERTRAIL_DMEM_CLEAR_EN
        // Sweep: busy for 256 cycles after reset; a request inside the window is ignored.
        cyc  = 0;
        acks = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge iClock); #1;
            if (oAck) acks++;
            if (i == 10) begin
                iData1BusEn  = 1'b1;
                iDataMem1RW  = 1'b0;
                iDataAddrBus = 32'h33;
            end
            if (i == 11) iData1BusEn = 1'b0;
            if (!oBusy) begin
                cyc = i;
                break;
            end
        end
        check("clear.busy_cycles", 32'(cyc), 32'd256);
        count_acks(6, c);
        check("clear.ignored_req_acks", 32'(acks + c), 32'd0);
        access("clear.rd_b1_10", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0000_0000);
        access("clear.rd_b2_ff", 1'b0, 1'b1, 1'b0, 1'b0, 32'hFF, 32'h0, 32'h0000_0000);
`endif

        // Basic write then read on bank 1.
        access("wr_b1_10", 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, oDataDataBus);
        access("rd_b1_10", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        repeat (5) @(posedge iClock);
        #1;
        check("rdata_held_idle", oDataDataBus, 32'hDEAD_BEEF);

        // Bank independence; a write leaves the read bus untouched.
        access("wr_b2_10", 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'hDEAD_BEEF);
        access("rd_b1_10_again", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        access("rd_b2_10", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h1234_5678);

        // Both enables: bank 1 read wins, bank 2 write is dropped.
        access("both_en", 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'hDEAD_BEEF);
        count_acks(4, c);
        check("both_en.extra_acks", 32'(c), 32'd0);
        access("rd_b2_after_both", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h1234_5678);

        // Address wrap, with a stray enable pulse during WAIT.
        @(negedge iClock);
        iData1BusEn  = 1'b1;
        iDataMem1RW  = 1'b1;
        iDataAddrBus = 32'h105;
        iDataDataBus = 32'hA5A5_A5A5;
        @(posedge iClock); #1;
        iData1BusEn = 1'b0;
        @(posedge iClock); #1;
        check("wrap_wr.busy_in_wait", {31'b0, oBusy}, 32'd1);
        iData1BusEn  = 1'b1;
        iDataMem1RW  = 1'b0;
        iDataAddrBus = 32'h10;
        @(posedge iClock); #1;
        iData1BusEn = 1'b0;
        @(posedge iClock); #1;
        check("wrap_wr.ack", {31'b0, oAck}, 32'd1);
        check("wrap_wr.rdata_unchanged", oDataDataBus, 32'h1234_5678);
        count_acks(6, c);
        check("wrap_wr.extra_acks", 32'(c), 32'd0);
        access("rd_b1_05_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'h05, 32'h0, 32'hA5A5_A5A5);

        // Reset during WAIT discards the pending write.
        access("wr_b1_20_seed", 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0055, 32'hA5A5_A5A5);
        @(negedge iClock);
        iData1BusEn  = 1'b1;
        iDataMem1RW  = 1'b1;
        iDataAddrBus = 32'h20;
        iDataDataBus = 32'h0000_0001;
        @(posedge iClock); #1;
        iData1BusEn = 1'b0;
        @(negedge iClock);
        iReset = 1'b1;
        @(posedge iClock); #1;
        check("rst_wait.ack", {31'b0, oAck}, 32'd0);
        check("rst_wait.rdata", oDataDataBus, 32'h0);
        @(negedge iClock);
        iReset = 1'b0;
`ifdef EMBERTRAIL_DMEM_CLEAR_EN
        wait_not_busy(cyc, acks);
        check("rst_wait.clear_cycles", 32'(cyc), 32'd256);
        check("rst_wait.acks", 32'(acks), 32'd0);
        access("rd_b1_20_after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0000_0000);
`else
        check("rst_wait.busy", {31'b0, oBusy}, 32'd0);
        count_acks(6, c);
        check("rst_wait.acks", 32'(c), 32'd0);
        access("rd_b1_20_after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0000_0055);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
